// File: rtl/siso_frame_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// Optional parity bit is enabled by defining SISO_FRAME_TX_PARITY_EN.
package siso_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Total bits on the line for one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_w, input int stop_bits, input bit parity);
    return 1 + data_w + (parity ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/siso_frame_tx_bit_tick_gen.sv
// Bit-period divider: one-cycle tick every BIT_DIV clocks, restartable by clr.
module bit_tick_gen #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/siso_frame_tx.sv
// Parallel-in serial-out frame transmitter: start, data LSB first, optional even
// parity (SISO_FRAME_TX_PARITY_EN), stop bits. Line idles high.
module siso_frame_tx
  import siso_frame_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_DIV   = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              so,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shreg_sh;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              so_q, so_d;
  logic              done_q, done_d;
  logic              accept;
  logic              tick;
`ifdef SISO_FRAME_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign accept   = din_valid && (state_q == IDLE);
  assign shreg_sh = shreg_q >> 1;

  bit_tick_gen #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  // so_d is the value the line takes after this edge, so it is chosen per transition.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    so_d       = so_q;
    done_d     = 1'b0;
`ifdef SISO_FRAME_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        so_d = 1'b1;
        if (din_valid) begin
          state_d    = START;
          shreg_d    = din;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          so_d       = 1'b0;
`ifdef SISO_FRAME_TX_PARITY_EN
          par_d      = ^din;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          so_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d   = shreg_sh;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SISO_FRAME_TX_PARITY_EN
            state_d    = PARITY;
            so_d       = par_q;
`else
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            so_d       = 1'b1;
`endif
          end else begin
            so_d = shreg_sh[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          so_d       = 1'b1;
        end
      end
      STOP: begin
        so_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        so_d    = 1'b1;
      end
    endcase
  end

  // Reset forces the line high at once and drops any frame without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      so_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      so_q       <= so_d;
      done_q     <= done_d;
    end
  end

`ifdef SISO_FRAME_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  assign din_ready = (state_q == IDLE);
  assign busy      = ~din_ready;
  assign so        = so_q;
  assign done      = done_q;

endmodule

// File: tb/tb_siso_frame_tx.sv
// Randomized self-checking bench for siso_frame_tx; expected line levels come
// from a frame model (start, data LSB first, optional parity, stop bits).
module tb_siso_frame_tx;
  import siso_frame_tx_pkg::*;

  localparam int DW   = 8;
  localparam int SB   = 1;
  localparam int BD_A = 1;
  localparam int BD_B = 4;
`ifdef SISO_FRAME_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int N = frame_bits(DW, SB, PAR);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          valid_a, valid_b;
  logic          ready_a, so_a, busy_a, done_a;
  logic          ready_b, so_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  siso_frame_tx #(.DATA_W(DW), .BIT_DIV(BD_A), .STOP_BITS(SB)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(valid_a),
    .din_ready(ready_a), .so(so_a), .busy(busy_a), .done(done_a)
  );

  siso_frame_tx #(.DATA_W(DW), .BIT_DIV(BD_B), .STOP_BITS(SB)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(valid_b),
    .din_ready(ready_b), .so(so_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level for frame bit idx of word w.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int idx);
    if (idx == 0)               return 1'b0;
    if (idx <= DW)              return w[idx-1];
    if (PAR && idx == DW + 1)   return ^w;
    return 1'b1;
  endfunction

  // {so, ready, busy, done} of the selected instance.
  function automatic logic [3:0] obs(input int sel);
    if (sel == 0) return {so_a, ready_a, busy_a, done_a};
    return {so_b, ready_b, busy_b, done_b};
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) valid_a = v;
    else          valid_b = v;
  endtask

  // Called and returns at a falling edge. Sends one word and checks every cycle of
  // the frame plus the done cycle. keep leaves din_valid high with busy_din on din.
  task automatic send(input int sel, input logic [DW-1:0] w, input bit noise,
                      input bit keep, input logic [DW-1:0] busy_din, output int t_acc);
    int bd;
    logic [3:0] o;
    bd = (sel == 0) ? BD_A : BD_B;
    o = obs(sel);
    check($sformatf("ready_pre%0d", sel), o[2], 1'b1);
    din = w;
    set_valid(sel, 1'b1);
    t_acc = cyc;
    for (int k = 0; k < N * bd; k++) begin
      @(negedge clk);
      o = obs(sel);
      check($sformatf("so%0d[%0d]", sel, k), o[3], exp_bit(w, k / bd));
      check($sformatf("busy%0d[%0d]", sel, k), o[1], 1'b1);
      check($sformatf("done%0d[%0d]", sel, k), o[0], 1'b0);
      if (keep) begin
        din = busy_din;
      end else if (noise) begin
        din = DW'($urandom);
        set_valid(sel, 1'($urandom));
      end else begin
        set_valid(sel, 1'b0);
      end
    end
    @(negedge clk);
    o = obs(sel);
    check($sformatf("done_pulse%0d", sel), o[0], 1'b1);
    check($sformatf("ready_end%0d", sel), o[2], 1'b1);
    check($sformatf("so_end%0d", sel), o[3], 1'b1);
    if (!keep) set_valid(sel, 1'b0);
  endtask

  initial begin
    int t1, t2;
    logic [3:0] o;
    logic [DW-1:0] w;
    rst = 1'b1; din = '0; valid_a = 1'b0; valid_b = 1'b0;
    #2;
    check("rst_so", so_a, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle after reset: outputs hold.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_a", {so_a, ready_a, busy_a, done_a}, 4'b1100);
      check("idle_b", {so_b, ready_b, busy_b, done_b}, 4'b1100);
    end

    send(0, 8'hA5, 1'b0, 1'b0, '0, t1);
    send(0, 8'h07, 1'b0, 1'b0, '0, t1);

    // Back-to-back with din_valid held: 0x00 then 0xFF, din driven 0xFF while busy.
    send(0, 8'h00, 1'b0, 1'b1, 8'hFF, t1);
    send(0, 8'hFF, 1'b0, 1'b0, '0, t2);
    check("accept_gap", t2 - t1, N * BD_A + 1);

    send(1, 8'h01, 1'b0, 1'b0, '0, t1);

    // Reset during data bit 3 of 0xA5.
    din = 8'hA5; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_bit3", so_a, exp_bit(8'hA5, 4));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_line", {so_a, ready_a, busy_a, done_a}, 4'b1100);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      check("post_rst_idle", {so_a, ready_a, busy_a, done_a}, 4'b1100);
    end
    send(0, 8'h3C, 1'b0, 1'b0, '0, t1);

    // Random words, random gaps, din/din_valid noise while busy.
    for (int i = 0; i < 30; i++) begin
      w = DW'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send((i % 3 == 2) ? 1 : 0, w, 1'b1, 1'b0, '0, t1);
    end

    @(negedge clk);
    o = obs(1);
    check("final_b_idle", o, 4'b1100);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/siso_frame_tx.md
# siso_frame_tx

Parallel-in, serial-out frame transmitter that is the upstream stage of the SISO shift register and drives its `si` input. It accepts one DATA_W-bit word per valid/ready handshake and serialises it as one frame. The frame is a start bit, the data LSB first, an optional even-parity bit, then stop bits. The line idles high between frames.

## Interface
- DATA_W, 8: data word width, 1..32.
- BIT_DIV, 1: clock cycles per serial bit, ≥1.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; **one clock; reset is asynchronous and active-high**.
- din  input  DATA_W  word to transmit; sampled only on the accept edge.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can accept; high only in IDLE.
- so  output  1  serial line, registered; feeds the SISO `si`.
- busy  output  1  frame in progress; equals ~din_ready.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: state IDLE, so=1, din_ready=1, busy=0, done=0, all counters 0.
- An accept happens on a rising edge where din_valid && din_ready.
  - On that edge, din is captured into the shift register and parity = ^din is captured.
- din_valid while busy is ignored. Changes on din after the accept have no effect.
- FSM states and exits:
  - IDLE → START on accept.
  - START (so=0) → DATA after BIT_DIV cycles.
  - DATA (so = shreg[0]; shift right once per bit) → PARITY, or → STOP when no parity, after DATA_W bits.
  - PARITY (so = captured parity) → STOP after 1 bit.
  - STOP (so=1) → IDLE after STOP_BITS bits.
- Frame length N = 1 + DATA_W + P + STOP_BITS bits, with P=1 only under PARITY_EN.
- Bit timing comes from a divide counter 0..BIT_DIV-1 that produces a tick on its terminal count. State and bit counters advance only on a tick. With BIT_DIV=1 the tick is every cycle.
- Widths:
  - Bit counter: $clog2(DATA_W+1) bits.
  - Divide counter: max(1, $clog2(BIT_DIV)) bits.
  - Stop counter: 1 bit.
- Reset mid-frame: so=1 immediately (asynchronous). The frame is dropped and no done is issued. The next accept after reset release produces a clean frame.

## Timing
- Accept edge E0: so goes 0 after E0 and holds for BIT_DIV cycles.
- Data bit i is on so from E0+(1+i)·BIT_DIV to E0+(2+i)·BIT_DIV.
- At edge E0+N·BIT_DIV: state=IDLE, so=1, done=1 for exactly one cycle, din_ready=1.
- Earliest next accept is at E0+N·BIT_DIV+1, so the minimum frame period is N·BIT_DIV+1 cycles.
- Latency from accept to first data bit is BIT_DIV cycles.
- so is glitch-free because it is driven from a flop.

## Configuration
- `SISO_FRAME_TX_PARITY_EN` defined:
  - The PARITY state is present and sends an even-parity bit after the data.
  - N = DATA_W + STOP_BITS + 2.
- Not defined:
  - No PARITY state and no parity flop.
  - DATA goes straight to STOP, and N = DATA_W + STOP_BITS + 1.

## Structure
- Package `siso_frame_tx_pkg`:
  - State typedef enum: IDLE, START, DATA, PARITY, STOP. PARITY is present always; it is unreachable when parity is off.
  - Localparam function `frame_bits(DATA_W, STOP_BITS, parity)`.
- One sub-module, `bit_tick_gen`:
  - Parameter BIT_DIV.
  - Ports: clk, rst, clr (restart count on accept), tick.
- Top level holds the FSM, shift register, bit and stop counters, and the done flop.

## Test plan
Unless noted, DATA_W=8, BIT_DIV=1, STOP_BITS=1.
- Reset with no stimulus → so=1, din_ready=1, busy=0, done=0. Outputs hold for 20 cycles.
- Parity off, send 0xA5 → so over 10 cycles = 0,1,0,1,0,0,1,0,1,1. Then done pulses once at E0+10 and din_ready=1.
- PARITY_EN, send 0x07 → so = 0,1,1,1,0,0,0,0,0,1(parity),1. done at E0+11.
- din_valid held high with 0x00 then 0xFF, parity off → accepts exactly 11 cycles apart. The second frame's data bits are all 1. din changes while busy do not alter so.
- BIT_DIV=4, send 0x01 → so low for cycles 0-3 (start), high for 4-7 (bit 0), low for 8-35. Stop high for 36-39, done at E0+40.
- rst pulsed during data bit 3 of 0xA5 → so=1 within the reset edge and no done pulse. Next frame 0x3C transmits correctly: 0,0,0,1,1,1,1,0,0,1.
